// File: rtl/mem_pkg.sv
// Data-memory access definitions shared by the pipeline and the store buffer:
// access-size codes, their byte sizes, and the queued-store entry format.
package mem_pkg;

    localparam logic [2:0] SEL_W  = 3'd0;
    localparam logic [2:0] SEL_H  = 3'd1;
    localparam logic [2:0] SEL_B  = 3'd2;
    localparam logic [2:0] SEL_HU = 3'd3;
    localparam logic [2:0] SEL_BU = 3'd4;

    localparam int SB_ADDR_W = 5;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [2:0]           sel;
    } sb_entry_t;

    function automatic logic [2:0] access_size(input logic [2:0] sel);
        case (sel)
            SEL_W:          return 3'd4;
            SEL_H, SEL_HU:  return 3'd2;
            default:        return 3'd1;
        endcase
    endfunction

    // Stores only come in W, H and B; anything else is written as a byte.
    function automatic logic [2:0] store_sel(input logic [2:0] sel);
        return (sel == SEL_W || sel == SEL_H) ? sel : SEL_B;
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO of queued stores; exposes every slot's address/size and a
// valid bit so the parent can check loads against all pending stores at once.
module store_buffer_fifo
    import mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  sb_entry_t            push_entry,
    output sb_entry_t            head_entry,
    output logic [SB_ADDR_W-1:0] ent_addr [DEPTH],
    output logic [2:0]           ent_sel  [DEPTH],
    output logic [DEPTH-1:0]     valid,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    sb_entry_t     mem_q [DEPTH];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; slot validity comes
    // from head/count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= push_entry;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] offset;
        assign offset      = PW'(i) - head_q;
        assign valid[i]    = {1'b0, offset} < count_q;
        assign ent_addr[i] = mem_q[i].addr;
        assign ent_sel[i]  = mem_q[i].sel;
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port data memory: loads own the
// port, queued stores drain in free cycles, overlapping loads and fences wait.
module store_buffer
    import mem_pkg::*;
#(
    parameter  int DATA_WIDTH  = SB_DATA_W,
    parameter  int D_ADD_WIDTH = SB_ADDR_W,
    parameter  int DEPTH       = 4,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   req_write,
    input  logic                   req_read,
    input  logic                   req_fence,
    input  logic [D_ADD_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]  req_data,
    input  logic [2:0]             req_sel,
    input  logic                   drain_hold,
    output logic                   stall,
    output logic                   mem_write,
    output logic                   mem_read,
    output logic [D_ADD_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [2:0]             mem_sel,
    output logic                   empty,
    output logic [CW-1:0]          count
);

    sb_entry_t            push_entry;
    sb_entry_t            head_entry;
    logic [SB_ADDR_W-1:0] ent_addr [DEPTH];
    logic [2:0]           ent_sel  [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic                 full;
    logic                 conflict;
    logic                 read_go;
    logic                 drain;
    logic                 write_req;
    logic                 accept;

    // Byte ranges [b, b+lb) and [a, a+sa) intersect modulo the address space.
    function automatic logic overlaps(input logic [D_ADD_WIDTH-1:0] b,
                                      input logic [2:0]             lb,
                                      input logic [D_ADD_WIDTH-1:0] a,
                                      input logic [2:0]             sa);
        logic [D_ADD_WIDTH-1:0] fwd;
        logic [D_ADD_WIDTH-1:0] back;
        fwd  = b - a;
        back = a - b;
        return (fwd < D_ADD_WIDTH'(sa)) || (back < D_ADD_WIDTH'(lb));
    endfunction

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && overlaps(req_addr, access_size(req_sel),
                                     D_ADD_WIDTH'(ent_addr[i]),
                                     access_size(ent_sel[i])))
                conflict = 1'b1;
        end
    end

    // A simultaneous read+write is treated as a read only.
    assign write_req = req_write & ~req_read;
    assign read_go   = req_read & ~conflict;
    assign drain     = ~empty & ~drain_hold & ~read_go;
    assign accept    = write_req & (~full | drain);

    assign stall = (req_read & conflict)
                 | (write_req & full & ~drain)
                 | (req_fence & ~empty);

    always_comb begin
        push_entry      = '0;
        push_entry.addr = SB_ADDR_W'(req_addr);
        push_entry.data = SB_DATA_W'(req_data);
        push_entry.sel  = store_sel(req_sel);
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        if (read_go) begin
            mem_read = 1'b1;
            mem_addr = req_addr;
            mem_sel  = req_sel;
        end else if (drain) begin
            mem_write = 1'b1;
            mem_addr  = D_ADD_WIDTH'(head_entry.addr);
            mem_wdata = DATA_WIDTH'(head_entry.data);
            mem_sel   = head_entry.sel;
        end
    end

    store_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (Clk),
        .rst        (Rst),
        .push       (accept),
        .pop        (drain),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .ent_addr   (ent_addr),
        .ent_sel    (ent_sel),
        .valid      (valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the EX/MEM pipeline register and the data memory in the 5-stage RV32I core.
- MEM-stage stores are accepted in one cycle and queued. They drain to the single-port byte-addressed data memory in cycles when no load uses the port.
- Loads have port priority. A load whose bytes overlap any queued store stalls until the overlapping entries have drained.
- A fence request stalls until the buffer is empty.

Parameters:
- DATA_WIDTH, 32, data width of stores and of the memory port
- D_ADD_WIDTH, 5, byte-address width; all address arithmetic is modulo 2**D_ADD_WIDTH, matching the memory
- DEPTH, 4, number of buffer entries (power of two, ≥2)

Ports:
- Clk  in  1  clock
- Rst  in  1  reset
- req_write  in  1  MEM-stage store request
- req_read  in  1  MEM-stage load request
- req_fence  in  1  fence: complete all queued stores
- req_addr  in  D_ADD_WIDTH  byte address
- req_data  in  DATA_WIDTH  store data
- req_sel  in  3  access size code (shared package)
- drain_hold  in  1  inhibit draining (debug/test)
- stall  out  1  request not accepted this cycle; pipeline holds it
- mem_write  out  1  write strobe to data memory
- mem_read  out  1  read strobe to data memory
- mem_addr  out  D_ADD_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_sel  out  3  memory size code
- empty  out  1  count==0
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Rst.
- Reset:
  - count, head and tail pointers clear to 0; entries need not clear; pending stores are discarded.
  - Next cycle: empty=1, mem_write=0.
  - mem_read, stall and the mem_* address/data/sel outputs are combinational. They follow the current requests against the now-empty buffer.
- Sizes:
  - size(sel): W=4, H/HU=2, B/BU=1.
  - Store sels are W, H, B only; a store with any other sel is treated as B.
- Overlap of a load (address b, size lb) with an entry (address a, size sa):
  - True when ((b-a) mod 2**N) < sa or ((a-b) mod 2**N) < lb, where N = D_ADD_WIDTH.
  - conflict = OR of the overlap test over all valid entries.
- Load path (combinational, zero latency):
  - When req_read and !conflict: mem_read=1, mem_addr=req_addr, mem_sel=req_sel, and there is no drain this cycle.
  - When req_read and conflict: stall=1, mem_read=0, and draining is allowed.
- Drain:
  - Condition: count>0 and !drain_hold and not (req_read and !conflict).
  - When the condition holds: mem_write=1 and head entry drives mem_addr, mem_wdata, mem_sel. The head pops at the clock edge.
- Store acceptance:
  - Condition: req_write and (count<DEPTH or drain this cycle).
  - On acceptance the store enqueues at the tail at the clock edge, stall=0.
  - If full with no drain: stall=1.
  - Enqueue and drain in the same cycle leave count unchanged.
  - A store is never written to memory in its acceptance cycle. The earliest write is the following cycle.
- Fence: stall=1 while count>0; released in the first cycle count==0.
- req_read with req_write is illegal (bench assertion). RTL treats it as a read only.
- stall = (req_read & conflict) | (req_write & count==DEPTH & !drain) | (req_fence & count!=0).
- Idle outputs: when neither read nor drain occurs, mem_read=mem_write=0 and mem_addr/mem_wdata/mem_sel=0.
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH, never exceeds it.

Decomposition:
- Package mem_pkg holds:
  - sel encoding constants SEL_W=0, SEL_H=1, SEL_B=2, SEL_HU=3, SEL_BU=4
  - function access_size(sel)
  - typedef sb_entry_t {addr, data, sel}
- One sub-module, store_buffer_fifo: circular FIFO of sb_entry_t with push/pop, count and full/empty, exposing all entries plus valid bits for the overlap check.
- Overlap logic and arbitration live in store_buffer.

Test Plan:
- Reset, then single store W addr 0x04 data 0xDEADBEEF, no loads → cycle 0 stall=0, count=1. Cycle 1 mem_write=1, mem_addr=0x04, mem_wdata=0xDEADBEEF, mem_sel=0. Cycle 2 empty=1.
- drain_hold=1, five back-to-back W stores → stores 1-4 accepted, count=4. The fifth gets stall=1 until drain_hold drops. Then it is accepted in the same cycle entry 1 drains, count stays 4.
- Queue B store addr 0x06 with drain_hold=1, then load H addr 0x05 → stall=1, mem_read=0. Release drain_hold: the store drains, then the next cycle mem_read=1 with mem_addr=0x05.
- Queue W store addr 0x1E (bytes 0x1E,0x1F,0x00,0x01), then load B addr 0x01 → conflict via wrap, stall=1. A load B at 0x02 issues immediately with mem_read=1 and no drain that cycle.
- Three queued stores, req_fence=1 → stall=1 for exactly 3 cycles of drain, then 0 with empty=1.
- Two queued stores, Rst=1 for one cycle → next cycle count=0, empty=1, mem_write=0. Neither store is ever written.
